regfile_write_arbiter: RTL

- Shares the register file's single write port between three writers.
  - Pipeline writeback (wb): ALU/load results.
  - Link writer (lnk): jal $31, jalr rd.
  - Multi-cycle unit (mdu): mult/div results.
- Fixed priority with starvation promotion.
- Registered write port: one commit per cycle, 1-cycle latency. Drives the register file's negedge-sampled write inputs.

---
 rtl/regfile_write_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between three writers:
//   pipeline writeback (wb), link writer (lnk) and the multi-cycle unit (mdu).
//   Base priority is wb > lnk > mdu. A lower-priority requester that has been
//   denied STARVE_LIMIT consecutive cycles is promoted above wb; lnk wins if
//   both are promoted. The winning write is registered, so it commits on the
//   posedge after the grant cycle. Writes to $0 take the slot but commit with
//   rf_we=0.
//
// Parameters
//   STARVE_LIMIT  consecutive denied cycles before promotion (1..15)
//   CNT_W         width of each starvation counter
//
// Ports
//   clock, reset                     clock (posedge), async active-low reset
//   {wb,lnk,mdu}_req/addr/data/pc    write requests, held until granted
//   {wb,lnk,mdu}_gnt                 combinational grants (one-hot or zero)
//   rf_we, rf_waddr, rf_wdata        registered register-file write port
//   busy_mask                        registers with a pending or committing write
//
// Optional feature
//   REGFILE_WRITE_TRACE_EN: registers the granted pc next to the data and
//   prints "@<pc>: $<addr> <= <data>" for every commit with rf_we=1.

module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_req,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  output logic        wb_gnt,
  input  logic        lnk_req,
  input  logic [4:0]  lnk_addr,
  input  logic [31:0] lnk_data,
  input  logic [31:0] lnk_pc,
  output logic        lnk_gnt,
  input  logic        mdu_req,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic [31:0] mdu_pc,
  output logic        mdu_gnt,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy_mask
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] lnk_cnt_q, lnk_cnt_d;
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic        lnk_starved, mdu_starved, any_gnt;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  // A counter can still read Limit in the cycle its req drops; qualify with req.
  assign lnk_starved = lnk_req && (lnk_cnt_q == Limit);
  assign mdu_starved = mdu_req && (mdu_cnt_q == Limit);

  always_comb begin
    wb_gnt  = 1'b0;
    lnk_gnt = 1'b0;
    mdu_gnt = 1'b0;
    if (reset) begin
      if (lnk_starved)      lnk_gnt = 1'b1;
      else if (mdu_starved) mdu_gnt = 1'b1;
      else if (wb_req)      wb_gnt  = 1'b1;
      else if (lnk_req)     lnk_gnt = 1'b1;
      else if (mdu_req)     mdu_gnt = 1'b1;
    end
  end

  assign any_gnt = wb_gnt | lnk_gnt | mdu_gnt;

  always_comb begin
    sel_addr = wb_addr;
    sel_data = wb_data;
    if (lnk_gnt) begin
      sel_addr = lnk_addr;
      sel_data = lnk_data;
    end else if (mdu_gnt) begin
      sel_addr = mdu_addr;
      sel_data = mdu_data;
    end
  end

  always_comb begin
    lnk_cnt_d = lnk_cnt_q;
    if (!lnk_req || lnk_gnt)   lnk_cnt_d = '0;
    else if (lnk_cnt_q != Limit) lnk_cnt_d = lnk_cnt_q + CNT_W'(1);

    mdu_cnt_d = mdu_cnt_q;
    if (!mdu_req || mdu_gnt)   mdu_cnt_d = '0;
    else if (mdu_cnt_q != Limit) mdu_cnt_d = mdu_cnt_q + CNT_W'(1);
  end

  // A granted $0 write loads address/data but never raises the enable.
  always_comb begin
    rf_we_d    = any_gnt && (sel_addr != 5'd0);
    rf_waddr_d = any_gnt ? sel_addr : rf_waddr_q;
    rf_wdata_d = any_gnt ? sel_data : rf_wdata_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lnk_cnt_q  <= '0;
      mdu_cnt_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      lnk_cnt_q  <= lnk_cnt_d;
      mdu_cnt_q  <= mdu_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  always_comb begin
    busy_mask = '0;
    for (int n = 1; n < 32; n++) begin
      busy_mask[n] = (wb_req  && (wb_addr  == 5'(n))) ||
                     (lnk_req && (lnk_addr == 5'(n))) ||
                     (mdu_req && (mdu_addr == 5'(n))) ||
                     (rf_we_q && (rf_waddr_q == 5'(n)));
    end
  end

`ifdef REGFILE_WRITE_TRACE_EN
  logic [31:0] pc_q;
  logic [31:0] sel_pc;

  always_comb begin
    sel_pc = wb_pc;
    if (lnk_gnt)      sel_pc = lnk_pc;
    else if (mdu_gnt) sel_pc = mdu_pc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       pc_q <= '0;
    else if (any_gnt) pc_q <= sel_pc;
  end

  always @(posedge clock) begin
    if (reset && rf_we_q) $display("@%h: $%0d <= %h", pc_q, rf_waddr_q, rf_wdata_q);
  end
`else
  logic unused_pc;
  assign unused_pc = ^{wb_pc, lnk_pc, mdu_pc};
`endif

endmodule
